// File: rtl/cpu_pkg.sv
// Shared CPU constants: register file geometry defaults and bank-select encoding.
package cpu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    localparam logic BANK_INT = 1'b0;
    localparam logic BANK_FP  = 1'b1;

    // Only int x0 is hardwired; fp f0 is an ordinary register.
    function automatic logic is_hardwired(input logic fp, input logic idx_zero);
        return (fp == BANK_INT) && idx_zero;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for both register banks; an issue beats a same-cycle writeback.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    input  logic                  issue_fp,
    input  logic [1:0]            wb_valid,
    input  logic [1:0][AW-1:0]    wb_rd,
    input  logic [1:0]            wb_fp,
    output logic [1:0][NREG-1:0]  busy
);

    logic [1:0][NREG-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < NREG; r++) begin
                if (issue_valid && issue_fp == 1'(b) && issue_rd == AW'(r))
                    busy_nxt[b][r] = 1'b1;
                else if ((wb_valid[0] && wb_fp[0] == 1'(b) && wb_rd[0] == AW'(r)) ||
                         (wb_valid[1] && wb_fp[1] == 1'(b) && wb_rd[1] == AW'(r)))
                    busy_nxt[b][r] = 1'b0;
            end
        end
        busy_nxt[BANK_INT][0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

endmodule

// File: rtl/regfile_sb.sv
// Dual-bank (int/fp) register file with two bypassed read ports, two write ports and a scoreboard.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_idx,
    input  logic            rs1_fp,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_busy,
    input  logic [AW-1:0]   rs2_idx,
    input  logic            rs2_fp,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_fp,
    input  logic            wb0_valid,
    input  logic [AW-1:0]   wb0_rd,
    input  logic            wb0_fp,
    input  logic [XLEN-1:0] wb0_data,
    input  logic            wb1_valid,
    input  logic [AW-1:0]   wb1_rd,
    input  logic            wb1_fp,
    input  logic [XLEN-1:0] wb1_data
);

    logic [1:0]            wb_valid, wb_fp;
    logic [1:0][AW-1:0]    wb_rd;
    logic [1:0][XLEN-1:0]  wb_data;
    logic [1:0][NREG-1:0]  sb_busy;

    logic [1:0][AW-1:0]    rs_idx;
    logic [1:0]            rs_fp;
    logic [XLEN-1:0]       rs_data [2];
    logic                  rs_busy [2];

    logic [XLEN-1:0]       rf [2][NREG];

    assign wb_valid = {wb1_valid, wb0_valid};
    assign wb_fp    = {wb1_fp, wb0_fp};
    assign wb_rd    = {wb1_rd, wb0_rd};
    assign wb_data  = {wb1_data, wb0_data};
    assign rs_idx   = {rs2_idx, rs1_idx};
    assign rs_fp    = {rs2_fp, rs1_fp};

    assign rs1_data = rs_data[0];
    assign rs1_busy = rs_busy[0];
    assign rs2_data = rs_data[1];
    assign rs2_busy = rs_busy[1];

    // wb1 is applied last so it wins a same-register collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < NREG; r++)
                    rf[b][r] <= '0;
        end else begin
            for (int m = 0; m < 2; m++)
                if (wb_valid[m] && !is_hardwired(wb_fp[m], wb_rd[m] == '0))
                    rf[wb_fp[m]][wb_rd[m]] <= wb_data[m];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic h0, h1, hw;
        assign h0 = wb_valid[0] && wb_fp[0] == rs_fp[p] && wb_rd[0] == rs_idx[p];
        assign h1 = wb_valid[1] && wb_fp[1] == rs_fp[p] && wb_rd[1] == rs_idx[p];
        assign hw = is_hardwired(rs_fp[p], rs_idx[p] == '0);

        // A bypassed value is current, so it is never reported busy.
        assign rs_data[p] = (rst || hw) ? '0 :
                            h1 ? wb_data[1] :
                            h0 ? wb_data[0] : rf[rs_fp[p]][rs_idx[p]];
        assign rs_busy[p] = !rst && !hw && !h0 && !h1 && sb_busy[rs_fp[p]][rs_idx[p]];
    end

    regfile_scoreboard #(.NREG(NREG)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid && !is_hardwired(issue_fp, issue_rd == '0)),
        .issue_rd    (issue_rd),
        .issue_fp    (issue_fp),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_fp       (wb_fp),
        .busy        (sb_busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, async-reset sequence, then random traffic vs. a model.
module tb_regfile_sb;
    import cpu_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1_idx, rs2_idx, issue_rd, wb0_rd, wb1_rd;
    logic            rs1_fp, rs2_fp, issue_fp, wb0_fp, wb1_fp;
    logic            issue_valid, wb0_valid, wb1_valid;
    logic [XLEN-1:0] rs1_data, rs2_data, wb0_data, wb1_data;
    logic            rs1_busy, rs2_busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .rs1_idx(rs1_idx), .rs1_fp(rs1_fp), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
        .rs2_idx(rs2_idx), .rs2_fp(rs2_fp), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_fp(issue_fp),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_fp(wb0_fp), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_fp(wb1_fp), .wb1_data(wb1_data)
    );

    typedef struct { logic v; logic fp; logic [AW-1:0] rd; logic [XLEN-1:0] d; } port_t;
    typedef struct { logic fp; logic [AW-1:0] idx; logic [XLEN-1:0] ed; logic eb; } rd_t;
    typedef struct { port_t wb0; port_t wb1; port_t iss; rd_t r1; rd_t r2; } vec_t;

    // Reference state: plain register values and pending flags per bank.
    logic [XLEN-1:0] m_rf  [2][NREG];
    bit              m_bsy [2][NREG];

    function automatic port_t P(logic fp, int rd, logic [XLEN-1:0] d);
        port_t p; p.v = 1'b1; p.fp = fp; p.rd = AW'(rd); p.d = d; return p;
    endfunction
    function automatic port_t N();
        port_t p; p.v = 1'b0; p.fp = 1'b0; p.rd = '0; p.d = '0; return p;
    endfunction
    function automatic rd_t R(logic fp, int idx, logic [XLEN-1:0] ed, logic eb);
        rd_t r; r.fp = fp; r.idx = AW'(idx); r.ed = ed; r.eb = eb; return r;
    endfunction
    function automatic vec_t V(port_t w0, port_t w1, port_t is, rd_t a, rd_t b);
        vec_t v; v.wb0 = w0; v.wb1 = w1; v.iss = is; v.r1 = a; v.r2 = b; return v;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < NREG; r++) begin
                m_rf[b][r] = '0; m_bsy[b][r] = 1'b0;
            end
    endtask

    task automatic model_read(input port_t w0, input port_t w1, inout rd_t r);
        if (r.fp == BANK_INT && r.idx == 0) begin r.ed = '0; r.eb = 1'b0; end
        else if (w1.v && w1.fp == r.fp && w1.rd == r.idx) begin r.ed = w1.d; r.eb = 1'b0; end
        else if (w0.v && w0.fp == r.fp && w0.rd == r.idx) begin r.ed = w0.d; r.eb = 1'b0; end
        else begin r.ed = m_rf[r.fp][r.idx]; r.eb = m_bsy[r.fp][r.idx]; end
    endtask

    task automatic model_commit(input vec_t v);
        port_t w [2];
        w[0] = v.wb0; w[1] = v.wb1;
        for (int m = 0; m < 2; m++)
            if (w[m].v && !(w[m].fp == BANK_INT && w[m].rd == 0)) begin
                m_rf[w[m].fp][w[m].rd] = w[m].d;
                m_bsy[w[m].fp][w[m].rd] = 1'b0;
            end
        if (v.iss.v && !(v.iss.fp == BANK_INT && v.iss.rd == 0))
            m_bsy[v.iss.fp][v.iss.rd] = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wb0_valid = v.wb0.v; wb0_fp = v.wb0.fp; wb0_rd = v.wb0.rd; wb0_data = v.wb0.d;
        wb1_valid = v.wb1.v; wb1_fp = v.wb1.fp; wb1_rd = v.wb1.rd; wb1_data = v.wb1.d;
        issue_valid = v.iss.v; issue_fp = v.iss.fp; issue_rd = v.iss.rd;
        rs1_fp = v.r1.fp; rs1_idx = v.r1.idx; rs2_fp = v.r2.fp; rs2_idx = v.r2.idx;
    endtask

    task automatic check_reads(input string tag, input rd_t a, input rd_t b);
        chk({tag, " rs1_data"}, rs1_data, a.ed);
        chk({tag, " rs1_busy"}, {31'b0, rs1_busy}, {31'b0, a.eb});
        chk({tag, " rs2_data"}, rs2_data, b.ed);
        chk({tag, " rs2_busy"}, {31'b0, rs2_busy}, {31'b0, b.eb});
    endtask

    // Called just after a rising edge; checks same-cycle reads mid-cycle, then commits.
    task automatic run(input string tag, input vec_t v);
        drive(v);
        #4;
        check_reads(tag, v.r1, v.r2);
        @(posedge clk); #1;
        model_commit(v);
    endtask

    vec_t tbl [16];
    vec_t v;

    initial begin
        tbl[0]  = V(N(), N(), N(), R(BANK_INT, 5, 0, 0), R(BANK_FP, 5, 0, 0));
        tbl[1]  = V(P(BANK_INT, 5, 32'h12345678), N(), N(),
                    R(BANK_INT, 5, 32'h12345678, 0), R(BANK_FP, 5, 0, 0));
        tbl[2]  = V(N(), N(), N(), R(BANK_INT, 5, 32'h12345678, 0), R(BANK_FP, 5, 0, 0));
        tbl[3]  = V(P(BANK_INT, 0, 32'hFFFFFFFF), N(), P(BANK_INT, 0, 0),
                    R(BANK_INT, 0, 0, 0), R(BANK_FP, 0, 0, 0));
        tbl[4]  = V(P(BANK_FP, 0, 32'hFFFFFFFF), N(), N(),
                    R(BANK_INT, 0, 0, 0), R(BANK_FP, 0, 32'hFFFFFFFF, 0));
        tbl[5]  = V(N(), N(), N(), R(BANK_FP, 0, 32'hFFFFFFFF, 0), R(BANK_INT, 0, 0, 0));
        tbl[6]  = V(N(), N(), P(BANK_FP, 3, 0), R(BANK_FP, 3, 0, 0), R(BANK_INT, 3, 0, 0));
        tbl[7]  = V(N(), N(), N(), R(BANK_FP, 3, 0, 1), R(BANK_INT, 3, 0, 0));
        tbl[8]  = V(N(), P(BANK_FP, 3, 32'hCAFEF00D), N(),
                    R(BANK_FP, 3, 32'hCAFEF00D, 0), R(BANK_FP, 3, 32'hCAFEF00D, 0));
        tbl[9]  = V(N(), N(), N(), R(BANK_FP, 3, 32'hCAFEF00D, 0), R(BANK_INT, 3, 0, 0));
        tbl[10] = V(P(BANK_INT, 7, 32'h1), P(BANK_INT, 7, 32'h2), N(),
                    R(BANK_INT, 7, 32'h2, 0), R(BANK_INT, 7, 32'h2, 0));
        tbl[11] = V(N(), N(), P(BANK_INT, 9, 0), R(BANK_INT, 7, 32'h2, 0), R(BANK_INT, 9, 0, 0));
        tbl[12] = V(P(BANK_INT, 9, 32'hAA), N(), P(BANK_INT, 9, 0),
                    R(BANK_INT, 9, 32'hAA, 0), R(BANK_INT, 7, 32'h2, 0));
        tbl[13] = V(N(), N(), N(), R(BANK_INT, 9, 32'hAA, 1), R(BANK_FP, 9, 0, 0));
        tbl[14] = V(N(), P(BANK_INT, 9, 32'hBB), N(),
                    R(BANK_INT, 9, 32'hBB, 0), R(BANK_FP, 3, 32'hCAFEF00D, 0));
        tbl[15] = V(N(), N(), N(), R(BANK_INT, 9, 32'hBB, 0), R(BANK_FP, 9, 0, 0));

        rst = 1'b1;
        drive(V(N(), N(), N(), R(0, 0, 0, 0), R(0, 0, 0, 0)));
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        // Outputs stay zero under reset even with a matching write on the bus.
        drive(V(P(BANK_INT, 5, 32'hDEAD), P(BANK_FP, 5, 32'hBEEF), P(BANK_INT, 5, 0),
                R(BANK_INT, 5, 0, 0), R(BANK_FP, 5, 0, 0)));
        #1;
        check_reads("in_reset", R(BANK_INT, 5, 0, 0), R(BANK_FP, 5, 0, 0));
        @(posedge clk); #1;
        drive(V(N(), N(), N(), R(0, 0, 0, 0), R(0, 0, 0, 0)));
        rst = 1'b0;
        #1;

        for (int i = 0; i < 16; i++)
            run($sformatf("tbl[%0d]", i), tbl[i]);

        // x4 pending with value 0x55, then an asynchronous mid-cycle reset.
        run("x4_issue", V(N(), N(), P(BANK_INT, 4, 0), R(BANK_INT, 4, 0, 0), R(BANK_FP, 4, 0, 0)));
        run("x4_wb_reissue", V(P(BANK_INT, 4, 32'h55), N(), P(BANK_INT, 4, 0),
                               R(BANK_INT, 4, 32'h55, 0), R(BANK_INT, 4, 32'h55, 0)));
        drive(V(N(), N(), N(), R(BANK_INT, 4, 0, 0), R(BANK_INT, 7, 0, 0)));
        #4;
        check_reads("x4_before_rst", R(BANK_INT, 4, 32'h55, 1), R(BANK_INT, 7, 32'h2, 0));
        #1;
        rst = 1'b1;
        drive(V(P(BANK_INT, 4, 32'h77), N(), P(BANK_INT, 4, 0),
                R(BANK_INT, 4, 0, 0), R(BANK_INT, 7, 0, 0)));
        #1;
        check_reads("x4_async_rst", R(BANK_INT, 4, 0, 0), R(BANK_INT, 7, 0, 0));
        @(posedge clk); #1;
        check_reads("x4_rst_edge", R(BANK_INT, 4, 0, 0), R(BANK_INT, 7, 0, 0));
        drive(V(N(), N(), N(), R(BANK_INT, 4, 0, 0), R(BANK_FP, 3, 0, 0)));
        rst = 1'b0;
        model_clear();
        #4;
        check_reads("x4_after_rel", R(BANK_INT, 4, 0, 0), R(BANK_FP, 3, 0, 0));
        @(posedge clk); #1;
        run("x4_settled", V(N(), N(), N(), R(BANK_INT, 4, 0, 0), R(BANK_INT, 9, 0, 0)));

        // Random traffic over a narrow index range to force collisions.
        for (int c = 0; c < 500; c++) begin
            v.wb0 = P($urandom_range(0, 1), $urandom_range(0, 7), $urandom);
            v.wb1 = P($urandom_range(0, 1), $urandom_range(0, 7), $urandom);
            v.iss = P($urandom_range(0, 1), $urandom_range(0, 7), 0);
            v.wb0.v = ($urandom_range(0, 2) == 0);
            v.wb1.v = ($urandom_range(0, 2) == 0);
            v.iss.v = ($urandom_range(0, 1) == 0);
            v.r1 = R($urandom_range(0, 1), $urandom_range(0, 7), 0, 0);
            v.r2 = R($urandom_range(0, 1), $urandom_range(0, 7), 0, 0);
            model_read(v.wb0, v.wb1, v.r1);
            model_read(v.wb0, v.wb1, v.r2);
            run($sformatf("rand[%0d]", c), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
